warp_pc_scheduler: RTL

- Per-warp program-counter sequencer and fetch arbiter at the front of the GPU pipeline.
- Holds one PC per warp and round-robins ready warps onto a single instruction-fetch port using a valid/ready handshake.
- Advances, redirects or retires each warp's PC when decode/branch reports the outcome of that warp's fetched instruction.
- One instruction is in flight per warp (barrel-style issue).

---
 rtl/warp_pc_scheduler_pkg.sv | 29 ++
 rtl/warp_pc_scheduler_rr_arbiter.sv | 31 +++
 rtl/warp_pc_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/warp_pc_scheduler_pkg.sv
// Shared widths, state encodings and payload types for the warp PC scheduler.
package warp_pc_scheduler_pkg;

    localparam int unsigned PC_WIDTH  = 12;
    localparam int unsigned NUM_WARPS = 4;
    localparam int unsigned WARP_ID_W = $clog2(NUM_WARPS);

    typedef logic [PC_WIDTH-1:0]  pc_t;
    typedef logic [WARP_ID_W-1:0] warp_id_t;

    typedef enum logic [1:0] {
        WS_INACTIVE = 2'd0,
        WS_READY    = 2'd1,
        WS_WAIT     = 2'd2
    } warp_state_e;

    typedef enum logic [1:0] {
        SCH_IDLE = 2'd0,
        SCH_RUN  = 2'd1,
        SCH_DONE = 2'd2
    } sch_state_e;

    // Registered fetch request payload.
    typedef struct packed {
        warp_id_t warp;
        pc_t      pc;
    } fetch_req_t;

endpackage

// File: rtl/warp_pc_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter: first requester at or after ptr_i wins.
module warp_pc_scheduler_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    logic [IDX_W-1:0] cand;

    // N is a power of two, so the index add wraps for free.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr_i + IDX_W'(i);
            if (!gnt_vld_o && req_i[cand]) begin
                gnt_vld_o      = 1'b1;
                gnt_idx_o      = cand;
                gnt_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_pc_scheduler.sv
// Per-warp PC sequencer with round-robin fetch arbitration onto one valid/ready fetch port.
module warp_pc_scheduler
    import warp_pc_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic [NUM_WARPS-1:0] warp_en,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [PC_WIDTH-1:0]  fetch_pc,
    output logic [WARP_ID_W-1:0] fetch_warp,
    input  logic                 rslv_valid,
    input  logic [WARP_ID_W-1:0] rslv_warp,
    input  logic                 rslv_taken,
    input  logic [PC_WIDTH-1:0]  rslv_target,
    input  logic                 rslv_halt,
    output logic [NUM_WARPS-1:0] warp_active,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    sch_state_e           state_q, state_d;
    warp_state_e          ws_q [NUM_WARPS];
    warp_state_e          ws_d [NUM_WARPS];
    pc_t                  pc_q [NUM_WARPS];
    pc_t                  pc_d [NUM_WARPS];
    warp_id_t             ptr_q, ptr_d;
    logic                 fetch_valid_q, fetch_valid_d;
    fetch_req_t           fetch_q, fetch_d;
    logic                 busy_q, done_q, err_q, err_d;
    logic [NUM_WARPS-1:0] active_q, active_d;

    logic                 accept_c;
    logic                 load_c;
    logic                 launch_c;
    logic                 all_idle_c;
    logic [NUM_WARPS-1:0] req_c;
    logic [NUM_WARPS-1:0] gnt_oh_c;
    warp_id_t             gnt_idx_c;
    logic                 gnt_vld_c;
    pc_t                  gnt_pc_c;

    assign accept_c = fetch_valid_q & fetch_ready;
    assign load_c   = !fetch_valid_q || fetch_ready;
    assign launch_c = (state_q == SCH_IDLE) && start;

    // Ready warps compete, except the one whose request is being accepted right now.
    always_comb begin
        req_c      = '0;
        all_idle_c = 1'b1;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            req_c[w] = (ws_q[w] == WS_READY) &&
                       !(accept_c && (fetch_q.warp == WARP_ID_W'(w)));
            if (ws_q[w] != WS_INACTIVE) begin
                all_idle_c = 1'b0;
            end
        end
    end

    warp_pc_scheduler_rr_arbiter #(
        .N     (NUM_WARPS),
        .IDX_W (WARP_ID_W)
    ) u_arb (
        .req_i     (req_c),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (gnt_oh_c),
        .gnt_idx_o (gnt_idx_c),
        .gnt_vld_o (gnt_vld_c)
    );

    always_comb begin
        gnt_pc_c = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            if (gnt_oh_c[w]) begin
                gnt_pc_c = gnt_pc_c | pc_q[w];
            end
        end
    end

    // Top-level kernel FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCH_IDLE: begin
                if (start) begin
                    state_d = (warp_en != '0) ? SCH_RUN : SCH_DONE;
                end
            end
            SCH_RUN: begin
                if (all_idle_c && !fetch_valid_q) begin
                    state_d = SCH_DONE;
                end
            end
            SCH_DONE: state_d = SCH_IDLE;
            default:  state_d = SCH_IDLE;
        endcase
    end

    // Per-warp state and PC: launch, fetch acceptance, then resolve outcome.
    always_comb begin
        ws_d  = ws_q;
        pc_d  = pc_q;
        err_d = err_q;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            if (launch_c && warp_en[w]) begin
                ws_d[w] = WS_READY;
                pc_d[w] = start_pc;
            end
            if (accept_c && (fetch_q.warp == WARP_ID_W'(w))) begin
                ws_d[w] = WS_WAIT;
            end
        end
        if (rslv_valid) begin
            if (ws_q[rslv_warp] == WS_WAIT) begin
                if (rslv_halt) begin
                    ws_d[rslv_warp] = WS_INACTIVE;
                end else if (rslv_taken) begin
                    ws_d[rslv_warp] = WS_READY;
                    pc_d[rslv_warp] = rslv_target;
                end else begin
                    ws_d[rslv_warp] = WS_READY;
                    pc_d[rslv_warp] = pc_q[rslv_warp] + PC_WIDTH'(1);
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Fetch register only reloads when empty or being drained this cycle.
    always_comb begin
        fetch_valid_d = fetch_valid_q;
        fetch_d       = fetch_q;
        ptr_d         = ptr_q;
        if (load_c) begin
            fetch_valid_d = gnt_vld_c;
            if (gnt_vld_c) begin
                fetch_d.pc   = gnt_pc_c;
                fetch_d.warp = gnt_idx_c;
                ptr_d        = WARP_ID_W'(gnt_idx_c + 1'b1);
            end
        end
    end

    always_comb begin
        active_d = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            active_d[w] = (ws_d[w] != WS_INACTIVE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SCH_IDLE;
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                ws_q[w] <= WS_INACTIVE;
                pc_q[w] <= '0;
            end
            ptr_q         <= '0;
            fetch_valid_q <= 1'b0;
            fetch_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            active_q      <= '0;
        end else begin
            state_q       <= state_d;
            ws_q          <= ws_d;
            pc_q          <= pc_d;
            ptr_q         <= ptr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_q       <= fetch_d;
            busy_q        <= (state_d == SCH_RUN);
            done_q        <= (state_d == SCH_DONE);
            err_q         <= err_d;
            active_q      <= active_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_q.pc;
    assign fetch_warp  = fetch_q.warp;
    assign warp_active = active_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
